// File: rtl/alias_force_ctrl.sv
// Force/release controller for one net shared by NPORT aliased handles.
// Keeps per-bit override enable/value, resolves the net and counts request events.
module alias_force_ctrl #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NPORT = 3,
    parameter int unsigned CNTW  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       drv_i,
    input  logic [NPORT-1:0]       force_req_i,
    input  logic [NPORT*WIDTH-1:0] force_val_i,
    input  logic [NPORT*WIDTH-1:0] force_mask_i,
    input  logic [NPORT-1:0]       release_req_i,
    input  logic [NPORT*WIDTH-1:0] release_mask_i,
    output logic [WIDTH-1:0]       net_o,
    output logic [WIDTH-1:0]       forced_o,
    output logic [1:0]             state_o,
    output logic [CNTW-1:0]        force_cnt_o,
    output logic [CNTW-1:0]        release_cnt_o
);

    typedef enum logic [1:0] {
        ST_RELEASED = 2'd0,
        ST_PARTIAL  = 2'd1,
        ST_FORCED   = 2'd2
    } state_e;

    logic [WIDTH-1:0] fen, fval;
    logic [WIDTH-1:0] fen_nxt, fval_nxt;
    logic [WIDTH-1:0] claimed;
    logic [WIDTH-1:0] sel;
    logic [CNTW-1:0]  force_cnt, release_cnt;
    state_e           state;

    // Releases clear first, then forces set: a bit both forced and released stays forced.
    // Handles are walked in ascending order and a bit is claimed once, giving lowest-index priority.
    always_comb begin
        fen_nxt  = fen;
        fval_nxt = fval;
        claimed  = '0;
        sel      = '0;
        for (int unsigned k = 0; k < NPORT; k++) begin
            if (release_req_i[k]) begin
                fen_nxt = fen_nxt & ~release_mask_i[k*WIDTH +: WIDTH];
            end
        end
        for (int unsigned k = 0; k < NPORT; k++) begin
            if (force_req_i[k]) begin
                sel      = force_mask_i[k*WIDTH +: WIDTH] & ~claimed;
                fval_nxt = (fval_nxt & ~sel) | (force_val_i[k*WIDTH +: WIDTH] & sel);
                claimed  = claimed | sel;
            end
        end
        fen_nxt = fen_nxt | claimed;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fen  <= '0;
            fval <= '0;
        end else begin
            fen  <= fen_nxt;
            fval <= fval_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            force_cnt   <= '0;
            release_cnt <= '0;
        end else begin
            if (|force_req_i && force_cnt != '1) begin
                force_cnt <= force_cnt + CNTW'(1);
            end
            if (|release_req_i && release_cnt != '1) begin
                release_cnt <= release_cnt + CNTW'(1);
            end
        end
    end

    always_comb begin
        if (fen == '0) begin
            state = ST_RELEASED;
        end else if (fen == '1) begin
            state = ST_FORCED;
        end else begin
            state = ST_PARTIAL;
        end
    end

    assign net_o         = (fen & fval) | (~fen & drv_i);
    assign forced_o      = fen;
    assign state_o       = state;
    assign force_cnt_o   = force_cnt;
    assign release_cnt_o = release_cnt;

endmodule

// File: tb/tb_alias_force_ctrl.sv
// Randomized and directed bench for alias_force_ctrl against a per-bit behavioural model.
module tb_alias_force_ctrl;

    localparam int W = 16;
    localparam int N = 3;
    localparam int C = 8;
    localparam int CMAX = (1 << C) - 1;

    logic           clk = 1'b0;
    logic           clk_en = 1'b1;
    logic           rst_n = 1'b0;
    logic [W-1:0]   drv_i = '0;
    logic [N-1:0]   force_req_i = '0;
    logic [N-1:0]   release_req_i = '0;
    logic [N*W-1:0] force_val_i, force_mask_i, release_mask_i;
    logic [W-1:0]   net_o, forced_o;
    logic [1:0]     state_o;
    logic [C-1:0]   force_cnt_o, release_cnt_o;

    logic [W-1:0] fv [N];
    logic [W-1:0] fm [N];
    logic [W-1:0] rm [N];

    bit           m_fen [W];
    bit           m_fval [W];
    int           m_fcnt, m_rcnt;
    int           vectors = 0;
    int           miscompares = 0;

    alias_force_ctrl #(.WIDTH(W), .NPORT(N), .CNTW(C)) dut (
        .clk(clk), .rst_n(rst_n), .drv_i(drv_i),
        .force_req_i(force_req_i), .force_val_i(force_val_i), .force_mask_i(force_mask_i),
        .release_req_i(release_req_i), .release_mask_i(release_mask_i),
        .net_o(net_o), .forced_o(forced_o), .state_o(state_o),
        .force_cnt_o(force_cnt_o), .release_cnt_o(release_cnt_o)
    );

    always #5 if (clk_en) clk = ~clk;

    always_comb begin
        force_val_i    = '0;
        force_mask_i   = '0;
        release_mask_i = '0;
        for (int k = 0; k < N; k++) begin
            force_val_i[k*W +: W]    = fv[k];
            force_mask_i[k*W +: W]   = fm[k];
            release_mask_i[k*W +: W] = rm[k];
        end
    end

    function automatic void model_reset();
        for (int b = 0; b < W; b++) begin
            m_fen[b]  = 1'b0;
            m_fval[b] = 1'b0;
        end
        m_fcnt = 0;
        m_rcnt = 0;
    endfunction

    // Per bit: the first handle (lowest index) forcing it wins; otherwise any release clears it.
    function automatic void model_apply();
        for (int b = 0; b < W; b++) begin
            int  winner = -1;
            bit  rel = 1'b0;
            for (int k = N - 1; k >= 0; k--) begin
                if (force_req_i[k] && fm[k][b]) winner = k;
                if (release_req_i[k] && rm[k][b]) rel = 1'b1;
            end
            if (winner >= 0) begin
                m_fen[b]  = 1'b1;
                m_fval[b] = fv[winner][b];
            end else if (rel) begin
                m_fen[b] = 1'b0;
            end
        end
        if (force_req_i != 0) m_fcnt = (m_fcnt + 1 > CMAX) ? CMAX : m_fcnt + 1;
        if (release_req_i != 0) m_rcnt = (m_rcnt + 1 > CMAX) ? CMAX : m_rcnt + 1;
    endfunction

    function automatic logic [W-1:0] exp_net();
        logic [W-1:0] r;
        for (int b = 0; b < W; b++) r[b] = m_fen[b] ? m_fval[b] : drv_i[b];
        return r;
    endfunction

    function automatic logic [W-1:0] exp_forced();
        logic [W-1:0] r;
        for (int b = 0; b < W; b++) r[b] = m_fen[b];
        return r;
    endfunction

    function automatic logic [1:0] exp_state();
        int ones = 0;
        for (int b = 0; b < W; b++) ones += int'(m_fen[b]);
        if (ones == 0) return 2'd0;
        if (ones == W) return 2'd2;
        return 2'd1;
    endfunction

    task automatic clear_reqs();
        force_req_i   = '0;
        release_req_i = '0;
        for (int k = 0; k < N; k++) begin
            fv[k] = '0;
            fm[k] = '0;
            rm[k] = '0;
        end
    endtask

    task automatic step();
        model_apply();
        @(posedge clk);
        #1;
        clear_reqs();
    endtask

    task automatic test_reset();
        clear_reqs();
        model_reset();
        rst_n = 1'b0;
        drv_i = 16'h0000;
        #12;
        vectors++;
        if (net_o !== 16'h0000 || state_o !== 2'd0 || force_cnt_o !== 8'd0 || release_cnt_o !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_state: net=%h state=%0d fc=%0d rc=%0d, want 0000/0/0/0",
                     net_o, state_o, force_cnt_o, release_cnt_o);
        end
        drv_i = 16'h00ff;
        #1;
        vectors++;
        if (net_o !== 16'h00ff) begin
            miscompares++;
            $display("FAIL reset_drv_passthru: net=%h want 00ff", net_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_alias();
        logic [W-1:0] vals [N];
        vals[0] = 16'h1234;
        vals[1] = 16'h5678;
        vals[2] = 16'habcd;
        drv_i = 16'h0f0f;
        for (int k = 0; k < N; k++) begin
            force_req_i[k] = 1'b1;
            fv[k] = vals[k];
            fm[k] = '1;
            step();
            vectors++;
            if (net_o !== vals[k] || state_o !== 2'd2) begin
                miscompares++;
                $display("FAIL alias_force_h%0d: net=%h state=%0d want %h/2", k, net_o, state_o, vals[k]);
            end
            release_req_i[k] = 1'b1;
            rm[k] = '1;
            step();
            vectors++;
            if (net_o !== drv_i || state_o !== 2'd0) begin
                miscompares++;
                $display("FAIL alias_release_h%0d: net=%h state=%0d want %h/0", k, net_o, state_o, drv_i);
            end
        end
        vectors++;
        if (force_cnt_o !== 8'd3 || release_cnt_o !== 8'd3) begin
            miscompares++;
            $display("FAIL alias_counts: fc=%0d rc=%0d want 3/3", force_cnt_o, release_cnt_o);
        end
    endtask

    task automatic test_cross_release();
        drv_i = 16'h3c3c;
        force_req_i[2] = 1'b1;
        fv[2] = 16'hbeef;
        fm[2] = '1;
        step();
        vectors++;
        if (net_o !== 16'hbeef) begin
            miscompares++;
            $display("FAIL cross_force: net=%h want beef", net_o);
        end
        release_req_i[0] = 1'b1;
        rm[0] = '1;
        step();
        vectors++;
        if (net_o !== 16'h3c3c || state_o !== 2'd0) begin
            miscompares++;
            $display("FAIL cross_release: net=%h state=%0d want 3c3c/0", net_o, state_o);
        end
    endtask

    task automatic test_priority();
        int fc0 = m_fcnt;
        int rc0 = m_rcnt;
        drv_i = 16'h0000;
        force_req_i = 3'b011;
        fv[0] = 16'h1111; fm[0] = '1;
        fv[1] = 16'h2222; fm[1] = '1;
        release_req_i[2] = 1'b1; rm[2] = '1;
        step();
        vectors++;
        if (net_o !== 16'h1111 || state_o !== 2'd2 ||
            force_cnt_o !== 8'(fc0 + 1) || release_cnt_o !== 8'(rc0 + 1)) begin
            miscompares++;
            $display("FAIL priority_conflict: net=%h state=%0d fc=%0d rc=%0d want 1111/2/%0d/%0d",
                     net_o, state_o, force_cnt_o, release_cnt_o, fc0 + 1, rc0 + 1);
        end
    endtask

    task automatic test_partial();
        release_req_i[1] = 1'b1;
        rm[1] = '1;
        step();
        drv_i = 16'h5555;
        force_req_i[0] = 1'b1;
        fv[0] = 16'haaaa;
        fm[0] = 16'h00ff;
        step();
        vectors++;
        if (net_o !== 16'h55aa || state_o !== 2'd1 || forced_o !== 16'h00ff) begin
            miscompares++;
            $display("FAIL partial_force: net=%h state=%0d forced=%h want 55aa/1/00ff", net_o, state_o, forced_o);
        end
        release_req_i[1] = 1'b1;
        rm[1] = 16'h000f;
        step();
        vectors++;
        if (net_o !== 16'h55a5 || state_o !== 2'd1) begin
            miscompares++;
            $display("FAIL partial_release: net=%h state=%0d want 55a5/1", net_o, state_o);
        end
        // Zero-mask requests count as events but leave the override alone.
        force_req_i[2] = 1'b1;
        release_req_i[2] = 1'b1;
        step();
        vectors++;
        if (net_o !== 16'h55a5 || force_cnt_o !== 8'(m_fcnt) || release_cnt_o !== 8'(m_rcnt)) begin
            miscompares++;
            $display("FAIL zero_mask: net=%h fc=%0d rc=%0d want 55a5/%0d/%0d",
                     net_o, force_cnt_o, release_cnt_o, m_fcnt, m_rcnt);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            drv_i = 16'($urandom);
            for (int k = 0; k < N; k++) begin
                force_req_i[k]   = ($urandom_range(0, 3) == 0);
                release_req_i[k] = ($urandom_range(0, 3) == 0);
                fv[k] = 16'($urandom);
                fm[k] = ($urandom_range(0, 4) == 0) ? '1 : 16'($urandom & $urandom);
                rm[k] = ($urandom_range(0, 4) == 0) ? '1 : 16'($urandom | $urandom);
            end
            step();
            vectors++;
            if (net_o !== exp_net() || forced_o !== exp_forced() || state_o !== exp_state() ||
                force_cnt_o !== 8'(m_fcnt) || release_cnt_o !== 8'(m_rcnt)) begin
                miscompares++;
                $display("FAIL random_%0d: net=%h/%h forced=%h/%h state=%0d/%0d fc=%0d/%0d rc=%0d/%0d",
                         i, net_o, exp_net(), forced_o, exp_forced(), state_o, exp_state(),
                         force_cnt_o, m_fcnt, release_cnt_o, m_rcnt);
            end
            drv_i = 16'($urandom);
            #1;
            vectors++;
            if (net_o !== exp_net()) begin
                miscompares++;
                $display("FAIL random_drv_%0d: net=%h want %h", i, net_o, exp_net());
            end
        end
    endtask

    task automatic test_async_reset_sat();
        drv_i = 16'h7e7e;
        force_req_i[1] = 1'b1;
        fv[1] = 16'hc3c3;
        fm[1] = '1;
        step();
        vectors++;
        if (state_o !== 2'd2 || net_o !== 16'hc3c3) begin
            miscompares++;
            $display("FAIL pre_reset_forced: state=%0d net=%h want 2/c3c3", state_o, net_o);
        end
        @(negedge clk);
        clk_en = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (net_o !== 16'h7e7e || forced_o !== 16'h0000 || state_o !== 2'd0 || force_cnt_o !== 8'd0) begin
            miscompares++;
            $display("FAIL async_reset: net=%h forced=%h state=%0d fc=%0d want 7e7e/0000/0/0",
                     net_o, forced_o, state_o, force_cnt_o);
        end
        #5;
        rst_n = 1'b1;
        #3;
        clk_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            force_req_i[$urandom_range(0, N - 1)] = 1'b1;
            step();
            if (i == 254 || i == 255 || i == 299) begin
                vectors++;
                if (force_cnt_o !== 8'(m_fcnt)) begin
                    miscompares++;
                    $display("FAIL saturate_%0d: fc=%0d want %0d", i, force_cnt_o, m_fcnt);
                end
            end
        end
        vectors++;
        if (force_cnt_o !== 8'd255) begin
            miscompares++;
            $display("FAIL saturate_final: fc=%0d want 255", force_cnt_o);
        end
    endtask

    initial begin
        test_reset();
        test_alias();
        test_cross_release();
        test_priority();
        test_partial();
        test_random();
        test_async_reset_sat();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alias_force_ctrl.md
# alias_force_ctrl

Synthesizable force/release controller for one net shared by NPORT aliased handles. It sits directly upstream of alias-force test logic: it takes force/release requests issued through any alias handle, keeps per-bit override state, and drives the single resolved net value that every handle reads back. It also reports override state and counts force/release events for bench-side checking.

## Interface
- WIDTH, 16, net width in bits
- NPORT, 3, number of aliased handles that can issue requests (≥1)
- CNTW, 8, width of event counters
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- drv_i  in  WIDTH  normal (continuous) driver value of the net
- force_req_i  in  NPORT  per-handle force request, one-cycle pulse
- force_val_i  in  NPORT*WIDTH  per-handle force value; handle k at bits [k*WIDTH +: WIDTH]
- force_mask_i  in  NPORT*WIDTH  per-handle bit mask of bits to force, same packing
- release_req_i  in  NPORT  per-handle release request, one-cycle pulse
- release_mask_i  in  NPORT*WIDTH  per-handle bit mask of bits to release
- net_o  out  WIDTH  resolved net value, identical for all handles
- forced_o  out  WIDTH  per-bit override-active flags
- state_o  out  2  0=RELEASED, 1=PARTIAL, 2=FORCED
- force_cnt_o  out  CNTW  accepted force events, saturating
- release_cnt_o  out  CNTW  accepted release events, saturating

## Operation
- Registers: fen[WIDTH] (override enable), fval[WIDTH] (override value), two counters.
- net_o = (fen & fval) | (~fen & drv_i), combinational from registers and drv_i; drv_i changes show on unforced bits in the same cycle.
- All handles are aliases. A request on handle k acts on the one shared state. Requests carry no handle-local state.
- Force resolution per bit: among handles with force_req and mask bit set, the lowest index supplies the value. Set fen=1 and fval to that value.
- Release per bit: any handle with release_req and mask bit set clears fen. fval keeps its old value, so it is don't-care.
- Same bit forced and released in one cycle: force wins; the bit stays forced with the new value.
- Re-force of an already forced bit overwrites fval.
- A request with an all-zero mask has no effect on fen/fval. It still counts as an event.
- force_cnt increments by 1 per cycle in which any force_req bit is high, not per handle. release_cnt works the same way. Both saturate at 2^CNTW−1.
- state_o derived from fen: all zero → RELEASED; all one → FORCED; otherwise PARTIAL. It reflects the registered fen, not the next value.
- Transitions: RELEASED→FORCED/PARTIAL on force, FORCED→RELEASED on full release, FORCED↔PARTIAL on partial release/force. Any state can reach any state in one cycle.

## Timing
- Reset (rst_n low, async): fen=0, fval=0, counters=0. Outputs then read net_o=drv_i, forced_o=0, state_o=RELEASED, counts 0.
- Reset asserted mid-override clears every override immediately, without waiting for clk.
- Request sampled at rising edge N. From edge N, net_o, forced_o, state_o and the counters show the effect: 1-cycle latency, visible before edge N+1.
- Force at edge N and release at edge N+1 leaves the net forced for exactly one cycle. drv_i is visible again after edge N+1.
- No handshake. Requests are never back-pressured and always accepted.

## Test plan
- Reset with drv_i=16'h0000: hold rst_n low. Expect net_o=0, state_o=0, counts 0. Change drv_i to 16'h00ff; net_o=16'h00ff in the same cycle.
- Alias equivalence: force 16'h1234 full mask via handle 0, release via handle 0. Repeat with handle 1 and 16'h5678, then handle 2 and 16'habcd. Each value appears on net_o one cycle after its force, the driver returns after release, and the counts end at 3/3.
- Cross-handle release: force 16'hbeef via handle 2, release via handle 0. net_o=drv_i, state_o=RELEASED.
- Priority and conflict: in one cycle, handle 0 forces 16'h1111, handle 1 forces 16'h2222, handle 2 releases all. Expect net_o=16'h1111, state_o=FORCED, each counter +1.
- Partial: force mask 16'h00ff, value 16'haaaa, drv_i=16'h5555. Expect net_o=16'h55aa, state_o=PARTIAL. Then release mask 16'h000f: net_o=16'h55a5, state_o stays PARTIAL.
- Async reset mid-force and saturation: reset while state_o=FORCED, clocks stopped. net_o=drv_i immediately. Then issue 300 force pulses with CNTW=8; force_cnt_o holds at 255.
